// File: rtl/wb_periph_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_periph_arbiter
//  Purpose  : Wishbone slave-side controller that decodes an incoming SoC
//             access into one of N_SLV 4 KB peripheral windows, runs exactly
//             one transaction at a time and returns a registered response.
//             Unmapped addresses and peripherals that never ack are answered
//             with an error-ack (ERR_DATA) plus a one-cycle interrupt, so the
//             SoC bus can never stall.
//  Ports    : wb_clk_i / wb_rst_i      clock, synchronous active-high reset
//             wbs_*_i / wbs_*_o        Wishbone slave port towards the SoC
//             s_stb_o / s_cyc_o ...    one-hot strobed peripheral bus
//             s_ack_i / s_dat_i        per-peripheral ack and read data
//             err_irq_o                pulse on timeout or unmapped access
//             busy_o                   high while a transaction is in flight
//  Revision : 1.0  initial release
// ============================================================================
module wb_periph_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] BASE_MASK = 32'hFFFF_C000,
  parameter int          N_SLV     = 4,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic [N_SLV-1:0]     s_stb_o,
  output logic                 s_cyc_o,
  output logic                 s_we_o,
  output logic [3:0]           s_sel_o,
  output logic [11:0]          s_adr_o,
  output logic [31:0]          s_dat_o,
  input  logic [N_SLV-1:0]     s_ack_i,
  input  logic [32*N_SLV-1:0]  s_dat_i,
  output logic                 err_irq_o,
  output logic                 busy_o
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_REQ  = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;
  localparam logic [1:0] c_ST_ERR  = 2'd3;

  localparam logic [15:0] c_CNT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [15:0]      r_cnt;
  logic [1:0]       r_idx;

  logic [1:0]       w_idx;
  logic             w_hit;
  logic [N_SLV-1:0] w_onehot;
  logic             w_sel_ack;
  logic [31:0]      w_sel_dat;

  assign w_idx = wbs_adr_i[13:12];
  assign w_hit = (((wbs_adr_i ^ BASE_ADDR) & BASE_MASK) == 32'd0) &&
                 (32'(w_idx) < 32'(N_SLV));

  generate
    for (genvar k = 0; k < N_SLV; k++) begin : g_onehot
      assign w_onehot[k] = (w_idx == 2'(k));
    end
  endgenerate

  // Only the strobed peripheral's ack counts; s_stb_o is one-hot on the
  // selected window, so masking by it discards acks from idle peripherals.
  assign w_sel_ack = |(s_ack_i & s_stb_o);

  always_comb begin
    w_sel_dat = 32'd0;
    for (int k = 0; k < N_SLV; k++) begin
      if (r_idx == 2'(k)) begin
        w_sel_dat = s_dat_i[32*k +: 32];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= c_ST_IDLE;
      r_cnt     <= 16'd0;
      r_idx     <= 2'd0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
      s_stb_o   <= '0;
      s_cyc_o   <= 1'b0;
      s_we_o    <= 1'b0;
      s_sel_o   <= 4'd0;
      s_adr_o   <= 12'd0;
      s_dat_o   <= 32'd0;
      err_irq_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          wbs_ack_o <= 1'b0;
          err_irq_o <= 1'b0;
          if (wbs_cyc_i && wbs_stb_i) begin
            s_we_o  <= wbs_we_i;
            s_sel_o <= wbs_sel_i;
            s_adr_o <= wbs_adr_i[11:0];
            s_dat_o <= wbs_dat_i;
            r_cnt   <= 16'd0;
            busy_o  <= 1'b1;
            if (w_hit) begin
              r_idx   <= w_idx;
              s_stb_o <= w_onehot;
              s_cyc_o <= 1'b1;
              r_state <= c_ST_REQ;
            end else begin
              r_state <= c_ST_ERR;
            end
          end
        end

        c_ST_REQ: begin
          if (!wbs_cyc_i) begin
            // Master abandoned the cycle: release the peripheral silently.
            s_stb_o <= '0;
            s_cyc_o <= 1'b0;
            r_cnt   <= 16'd0;
            busy_o  <= 1'b0;
            r_state <= c_ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
            // Ack is tested first so an ack on the final timeout cycle wins.
            if (w_sel_ack) begin
              s_stb_o   <= '0;
              s_cyc_o   <= 1'b0;
              wbs_dat_o <= w_sel_dat;
              wbs_ack_o <= 1'b1;
              r_state   <= c_ST_RESP;
            end else if (r_cnt == c_CNT_LAST) begin
              s_stb_o   <= '0;
              s_cyc_o   <= 1'b0;
              wbs_dat_o <= ERR_DATA;
              wbs_ack_o <= 1'b1;
              err_irq_o <= 1'b1;
              r_state   <= c_ST_RESP;
            end
          end
        end

        c_ST_ERR: begin
          if (!wbs_cyc_i) begin
            busy_o  <= 1'b0;
            r_state <= c_ST_IDLE;
          end else begin
            wbs_dat_o <= ERR_DATA;
            wbs_ack_o <= 1'b1;
            err_irq_o <= 1'b1;
            r_state   <= c_ST_RESP;
          end
        end

        c_ST_RESP: begin
          wbs_ack_o <= 1'b0;
          err_irq_o <= 1'b0;
          r_cnt     <= 16'd0;
          busy_o    <= 1'b0;
          r_state   <= c_ST_IDLE;
        end

        default: begin
          r_state <= c_ST_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_periph_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_periph_arbiter
//  Purpose  : Self-checking bench for wb_periph_arbiter. A peripheral model
//             acks after a chosen number of strobe cycles; expected outcomes
//             come from a transaction-level model of the decode/timeout rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_periph_arbiter;

  localparam int          TO    = 255;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] MASK  = 32'hFFFF_C000;
  localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_adr_i, wbs_dat_i;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic [3:0]    s_stb_o;
  logic          s_cyc_o, s_we_o;
  logic [3:0]    s_sel_o;
  logic [11:0]   s_adr_o;
  logic [31:0]   s_dat_o;
  logic [3:0]    s_ack_i;
  logic [127:0]  s_dat_i;
  logic          err_irq_o, busy_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_periph_arbiter #(
    .BASE_ADDR(BASE), .BASE_MASK(MASK), .N_SLV(4), .TIMEOUT(TO), .ERR_DATA(ERRD)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .err_irq_o(err_irq_o), .busy_o(busy_o)
  );

  typedef struct {
    int          lat;       // cycles from request presentation to ack, -1 = none
    int          stb_cyc;   // cycles with any strobe high
    logic [3:0]  stb_seen;
    logic [31:0] dat;
    int          acks;
    int          irqs;
    logic        cyc_bad;
    logic        busy1;
    logic [11:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
  } obs_t;

  typedef struct {
    int          lat;
    int          stb_cyc;
    logic [3:0]  stb_seen;
    logic [31:0] dat;
    int          irqs;
  } exp_t;

  // Transaction-level reference: decode, then the peripheral either answers
  // within TO strobe cycles or the access is terminated with an error.
  function automatic exp_t model(input logic [31:0] adr, input int delay,
                                 input logic [31:0] pdata);
    exp_t e;
    int   idx;
    bit   hit;
    idx = int'(adr[13:12]);
    hit = (((adr ^ BASE) & MASK) == 32'd0) && (idx < 4);
    if (!hit) begin
      e.lat = 2; e.stb_cyc = 0; e.stb_seen = 4'd0; e.dat = ERRD; e.irqs = 1;
    end else if (delay >= 1 && delay <= TO) begin
      e.lat = delay + 1; e.stb_cyc = delay; e.stb_seen = 4'(1 << idx);
      e.dat = pdata; e.irqs = 0;
    end else begin
      e.lat = TO + 1; e.stb_cyc = TO; e.stb_seen = 4'(1 << idx);
      e.dat = ERRD; e.irqs = 1;
    end
    return e;
  endfunction

  // Master + peripheral driver. delay = strobe cycle in which the addressed
  // peripheral acks (0 = never); noise is OR-ed onto s_ack_i while strobed.
  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wdat, input int delay,
                         input logic [31:0] pdata, input logic [3:0] noise,
                         output obs_t o);
    int   idx;
    logic got;
    idx = int'(adr[13:12]);
    o.lat = -1; o.stb_cyc = 0; o.stb_seen = 4'd0; o.dat = 32'd0; o.acks = 0;
    o.irqs = 0; o.cyc_bad = 1'b0; o.busy1 = 1'b0; o.adr = 12'd0; o.we = 1'b0;
    o.sel = 4'd0; o.wdat = 32'd0;
    got = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_sel_i = sel;
    wbs_adr_i = adr; wbs_dat_i = wdat;
    for (int c = 1; c <= TO + 40; c++) begin
      @(posedge clk); #1;
      s_ack_i = 4'd0;
      s_dat_i = {$urandom, $urandom, $urandom, $urandom};
      s_dat_i[32*idx +: 32] = pdata;
      if (c == 1) o.busy1 = busy_o;
      if (s_cyc_o !== (|s_stb_o)) o.cyc_bad = 1'b1;
      if (wbs_ack_o === 1'b1) begin
        o.acks++;
        if (!got) begin
          got = 1'b1; o.lat = c; o.dat = wbs_dat_o;
          wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        end
      end
      if (err_irq_o === 1'b1) o.irqs++;
      if (s_stb_o !== 4'd0) begin
        o.stb_cyc++;
        o.stb_seen = o.stb_seen | s_stb_o;
        o.adr = s_adr_o; o.we = s_we_o; o.sel = s_sel_o; o.wdat = s_dat_o;
        if (o.stb_cyc == delay) s_ack_i[idx] = 1'b1;
        s_ack_i = s_ack_i | noise;
      end
      if (got && c >= o.lat + 4) break;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; s_ack_i = 4'd0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'd0;
    wbs_adr_i = 32'd0; wbs_dat_i = 32'd0; s_ack_i = 4'd0; s_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({wbs_ack_o, wbs_dat_o, s_stb_o, s_cyc_o, err_irq_o, busy_o} !== 40'd0) begin
      n_errors++;
      $display("FAIL reset_master_side: ack=%b dat=%h stb=%b cyc=%b irq=%b busy=%b, required all 0",
               wbs_ack_o, wbs_dat_o, s_stb_o, s_cyc_o, err_irq_o, busy_o);
    end
    n_checks++;
    if ({s_we_o, s_sel_o, s_adr_o, s_dat_o} !== 49'd0) begin
      n_errors++;
      $display("FAIL reset_periph_side: we=%b sel=%h adr=%h dat=%h, required all 0",
               s_we_o, s_sel_o, s_adr_o, s_dat_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_p1;
    obs_t o;
    run_txn(32'h3000_1004, 1'b0, 4'hF, 32'd0, 1, 32'h1234_5678, 4'd0, o);
    n_checks++;
    if (o.stb_seen !== 4'b0010 || o.adr !== 12'h004 || o.busy1 !== 1'b1) begin
      n_errors++;
      $display("FAIL read_p1_req: stb=%b adr=%h busy=%b, required 0010 004 1",
               o.stb_seen, o.adr, o.busy1);
    end
    n_checks++;
    if (o.lat != 2 || o.dat !== 32'h1234_5678 || o.acks != 1 || o.irqs != 0) begin
      n_errors++;
      $display("FAIL read_p1_resp: lat=%0d dat=%h acks=%0d irqs=%0d, required 2 12345678 1 0",
               o.lat, o.dat, o.acks, o.irqs);
    end
  endtask

  task automatic test_write_p3;
    obs_t o;
    run_txn(32'h3000_3010, 1'b1, 4'b0011, 32'hA5A5_0001, 5, 32'h0BAD_F00D, 4'd0, o);
    n_checks++;
    if (o.we !== 1'b1 || o.sel !== 4'b0011 || o.wdat !== 32'hA5A5_0001 ||
        o.adr !== 12'h010 || o.stb_seen !== 4'b1000) begin
      n_errors++;
      $display("FAIL write_p3_fields: we=%b sel=%b dat=%h adr=%h stb=%b, required 1 0011 a5a50001 010 1000",
               o.we, o.sel, o.wdat, o.adr, o.stb_seen);
    end
    n_checks++;
    if (o.stb_cyc != 5 || o.acks != 1 || o.lat != 6 || o.irqs != 0 || o.cyc_bad) begin
      n_errors++;
      $display("FAIL write_p3_seq: stb_cyc=%0d acks=%0d lat=%0d irqs=%0d cyc_bad=%b, required 5 1 6 0 0",
               o.stb_cyc, o.acks, o.lat, o.irqs, o.cyc_bad);
    end
  endtask

  task automatic test_timeout;
    obs_t o;
    run_txn(32'h3000_2000, 1'b0, 4'hF, 32'd0, 0, 32'h5555_AAAA, 4'd0, o);
    n_checks++;
    if (o.stb_cyc != TO || o.stb_seen !== 4'b0100 || o.lat != TO + 1 ||
        o.dat !== ERRD || o.irqs != 1 || o.acks != 1) begin
      n_errors++;
      $display("FAIL timeout: stb_cyc=%0d stb=%b lat=%0d dat=%h irqs=%0d acks=%0d, required %0d 0100 %0d deadbeef 1 1",
               o.stb_cyc, o.stb_seen, o.lat, o.dat, o.irqs, o.acks, TO, TO + 1);
    end
  endtask

  task automatic test_unmapped;
    obs_t o;
    run_txn(32'h3100_0000, 1'b0, 4'hF, 32'd0, 1, 32'h1111_1111, 4'd0, o);
    n_checks++;
    if (o.stb_cyc != 0 || o.lat != 2 || o.dat !== ERRD || o.irqs != 1 || o.acks != 1) begin
      n_errors++;
      $display("FAIL unmapped: stb_cyc=%0d lat=%0d dat=%h irqs=%0d acks=%0d, required 0 2 deadbeef 1 1",
               o.stb_cyc, o.lat, o.dat, o.irqs, o.acks);
    end
  endtask

  task automatic test_ack_on_timeout;
    obs_t o;
    run_txn(32'h3000_0100, 1'b0, 4'hF, 32'd0, TO, 32'hCAFE_0042, 4'd0, o);
    n_checks++;
    if (o.dat !== 32'hCAFE_0042 || o.irqs != 0 || o.lat != TO + 1 || o.acks != 1) begin
      n_errors++;
      $display("FAIL ack_on_timeout: dat=%h irqs=%0d lat=%0d acks=%0d, required cafe0042 0 %0d 1",
               o.dat, o.irqs, o.lat, o.acks, TO + 1);
    end
  endtask

  task automatic test_foreign_ack;
    obs_t o;
    run_txn(32'h3000_2040, 1'b0, 4'hF, 32'd0, 4, 32'h0000_2222, 4'b0001, o);
    n_checks++;
    if (o.stb_cyc != 4 || o.dat !== 32'h0000_2222 || o.lat != 5 || o.irqs != 0) begin
      n_errors++;
      $display("FAIL foreign_ack: stb_cyc=%0d dat=%h lat=%0d irqs=%0d, required 4 00002222 5 0",
               o.stb_cyc, o.dat, o.lat, o.irqs);
    end
  endtask

  task automatic test_reset_mid;
    int acks;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3000_2008; wbs_dat_i = 32'h1357_9BDF;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (s_stb_o !== 4'b0100 || busy_o !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_pre: stb=%b busy=%b, required 0100 1", s_stb_o, busy_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({wbs_ack_o, wbs_dat_o, s_stb_o, s_cyc_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
         err_irq_o, busy_o} !== 89'd0) begin
      n_errors++;
      $display("FAIL reset_mid: ack=%b dat=%h stb=%b cyc=%b we=%b sel=%h adr=%h sdat=%h irq=%b busy=%b, required all 0",
               wbs_ack_o, wbs_dat_o, s_stb_o, s_cyc_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
               err_irq_o, busy_o);
    end
    rst = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    acks = 0;
    repeat (4) begin @(posedge clk); #1; if (wbs_ack_o === 1'b1) acks++; end
    n_checks++;
    if (acks != 0) begin
      n_errors++;
      $display("FAIL reset_mid_noack: acks=%0d, required 0", acks);
    end
  endtask

  task automatic test_abort;
    int evts;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3000_0008; wbs_dat_i = 32'd0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (s_stb_o !== 4'b0001 || s_cyc_o !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_pre: stb=%b cyc=%b, required 0001 1", s_stb_o, s_cyc_o);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (s_stb_o !== 4'd0 || s_cyc_o !== 1'b0 || busy_o !== 1'b0 || wbs_ack_o !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_drop: stb=%b cyc=%b busy=%b ack=%b, required 0000 0 0 0",
               s_stb_o, s_cyc_o, busy_o, wbs_ack_o);
    end
    evts = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (wbs_ack_o === 1'b1 || err_irq_o === 1'b1) evts++;
    end
    n_checks++;
    if (evts != 0) begin
      n_errors++;
      $display("FAIL abort_quiet: ack_or_irq_cycles=%0d, required 0", evts);
    end
  endtask

  task automatic test_random;
    obs_t        o;
    exp_t        e;
    logic [31:0] adr, pdata, wdat, last;
    logic [3:0]  sel, noise;
    logic        we;
    int          delay, idx, r;
    for (int t = 0; t < 40; t++) begin
      idx = int'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) adr = $urandom;
      else adr = {18'h0C000, 2'(idx), 12'($urandom)};
      idx = int'(adr[13:12]);
      r = int'($urandom_range(0, 24));
      delay = (r == 0) ? 0 : (r == 1) ? TO : r;
      pdata = $urandom; wdat = $urandom; sel = 4'($urandom); we = 1'($urandom);
      noise = 4'($urandom) & ~4'(1 << idx);
      e = model(adr, delay, pdata);
      run_txn(adr, we, sel, wdat, delay, pdata, noise, o);
      n_checks++;
      if (o.lat != e.lat || o.dat !== e.dat || o.irqs != e.irqs || o.acks != 1) begin
        n_errors++;
        $display("FAIL rand_resp[%0d] adr=%h delay=%0d: lat=%0d dat=%h irqs=%0d acks=%0d, required %0d %h %0d 1",
                 t, adr, delay, o.lat, o.dat, o.irqs, o.acks, e.lat, e.dat, e.irqs);
      end
      n_checks++;
      if (o.stb_cyc != e.stb_cyc || o.stb_seen !== e.stb_seen || o.cyc_bad) begin
        n_errors++;
        $display("FAIL rand_strobe[%0d] adr=%h: stb_cyc=%0d stb=%b cyc_bad=%b, required %0d %b 0",
                 t, adr, o.stb_cyc, o.stb_seen, o.cyc_bad, e.stb_cyc, e.stb_seen);
      end
      if (e.stb_cyc > 0) begin
        n_checks++;
        if (o.we !== we || o.sel !== sel || o.wdat !== wdat || o.adr !== adr[11:0]) begin
          n_errors++;
          $display("FAIL rand_latch[%0d]: we=%b sel=%h dat=%h adr=%h, required %b %h %h %h",
                   t, o.we, o.sel, o.wdat, o.adr, we, sel, wdat, adr[11:0]);
        end
      end
      last = e.dat;
      repeat (2) begin @(posedge clk); #1; end
      n_checks++;
      if (wbs_dat_o !== last) begin
        n_errors++;
        $display("FAIL rand_hold[%0d]: wbs_dat_o=%h, required %h", t, wbs_dat_o, last);
      end
    end
  endtask

  initial begin
    test_reset;
    test_read_p1;
    test_write_p3;
    test_timeout;
    test_unmapped;
    test_ack_on_timeout;
    test_foreign_ack;
    test_reset_mid;
    test_abort;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
